// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX, forwarding, write-back and EX/MEM signal bundle for ex_stage
interface ex_stage_if #(
  parameter int DATA_W = 32
);
  // ID/EX instruction fields
  logic              idex_valid_i;
  logic [4:0]        idex_rs_i;
  logic [4:0]        idex_rt_i;
  logic [DATA_W-1:0] idex_rs_data_i;
  logic [DATA_W-1:0] idex_rt_data_i;
  logic [DATA_W-1:0] idex_imm_i;
  logic              idex_alu_src_i;
  logic [2:0]        idex_alu_op_i;
  logic [4:0]        idex_rd_i;
  logic [3:0]        idex_ctrl_i;
  // forwarding selects and MEM/WB write-back
  logic [1:0]        forwardA_i;
  logic [1:0]        forwardB_i;
  logic              wb_we_i;
  logic [4:0]        wb_rd_i;
  logic [DATA_W-1:0] wb_data_i;
  // stall and EX/MEM register
  logic              stall_o;
  logic              exmem_valid_o;
  logic [DATA_W-1:0] exmem_result_o;
  logic [DATA_W-1:0] exmem_store_o;
  logic [4:0]        exmem_rd_o;
  logic [3:0]        exmem_ctrl_o;

  modport master (
    output idex_valid_i, idex_rs_i, idex_rt_i, idex_rs_data_i, idex_rt_data_i,
           idex_imm_i, idex_alu_src_i, idex_alu_op_i, idex_rd_i, idex_ctrl_i,
           forwardA_i, forwardB_i, wb_we_i, wb_rd_i, wb_data_i,
    input  stall_o, exmem_valid_o, exmem_result_o, exmem_store_o, exmem_rd_o, exmem_ctrl_o
  );

  modport slave (
    input  idex_valid_i, idex_rs_i, idex_rt_i, idex_rs_data_i, idex_rt_data_i,
           idex_imm_i, idex_alu_src_i, idex_alu_op_i, idex_rd_i, idex_ctrl_i,
           forwardA_i, forwardB_i, wb_we_i, wb_rd_i, wb_data_i,
    output stall_o, exmem_valid_o, exmem_result_o, exmem_store_o, exmem_rd_o, exmem_ctrl_o
  );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS EX stage with EX/MEM register; iterative MUL, stall and patching under EX_MUL_EN
module ex_stage #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  ex_stage_if.slave bus
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store;
  logic [4:0]        ex_rd;
  logic [3:0]        ex_ctrl;
  logic              stall;
  logic [DATA_W-1:0] rs_res;
  logic [DATA_W-1:0] rt_res;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;

`ifdef EX_MUL_EN
  localparam int MUL_CYC = DATA_W / MUL_STEP;
  localparam int CNT_W   = $clog2(MUL_CYC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] mul_store;
  logic [4:0]        mul_rd;
  logic [3:0]        mul_ctrl;
  logic              mul_issue;
  logic              mul_done;
  logic [DATA_W-1:0] patch_a;
  logic [DATA_W-1:0] patch_b;
  logic              patch_a_vld;
  logic              patch_b_vld;
  logic [22:0]       idex_tag;
  logic [22:0]       idex_tag_q;
  logic              idex_changed;

  // MUL issue/completion decode, upstream stall and one shift-add step of the multiplier
  always_comb begin
    mul_issue = (state == IDLE) && bus.idex_valid_i && (bus.idex_alu_op_i == OP_MUL);
    mul_done  = (state == BUSY) && (cnt == CNT_W'(1));
    stall     = mul_issue || ((state == BUSY) && !mul_done);
    acc_next  = acc;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mul_b[j]) acc_next = acc_next + (mul_a << j);
    end
  end

  assign idex_tag = {bus.idex_valid_i, bus.idex_rs_i, bus.idex_rt_i, bus.idex_rd_i,
                     bus.idex_alu_op_i, bus.idex_ctrl_i};
  assign idex_changed = (idex_tag != idex_tag_q);

  // Patch registers catch write-backs that retire while the held instruction waits on a stall;
  // they are dropped once that instruction actually issues or when a different one appears
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      patch_a     <= '0;
      patch_b     <= '0;
      patch_a_vld <= 1'b0;
      patch_b_vld <= 1'b0;
      idex_tag_q  <= '0;
    end else begin
      idex_tag_q <= idex_tag;
      if (idex_changed || ((state == IDLE) && !stall)) begin
        patch_a_vld <= 1'b0;
        patch_b_vld <= 1'b0;
      end
      if (stall && bus.wb_we_i && (bus.wb_rd_i != 5'd0) && (bus.wb_rd_i == bus.idex_rs_i)) begin
        patch_a     <= bus.wb_data_i;
        patch_a_vld <= 1'b1;
      end
      if (stall && bus.wb_we_i && (bus.wb_rd_i != 5'd0) && (bus.wb_rd_i == bus.idex_rt_i)) begin
        patch_b     <= bus.wb_data_i;
        patch_b_vld <= 1'b1;
      end
    end
  end
`else
  logic unused_idx;

  assign stall      = 1'b0;
  assign unused_idx = ^{bus.idex_rs_i, bus.idex_rt_i, bus.wb_we_i, bus.wb_rd_i};
`endif

  // Operand resolution: EX/MEM forward, then MEM/WB forward, then patch, then register file
  always_comb begin
    rs_res = bus.idex_rs_data_i;
    rt_res = bus.idex_rt_data_i;
`ifdef EX_MUL_EN
    if (patch_a_vld) rs_res = patch_a;
    if (patch_b_vld) rt_res = patch_b;
`endif
    if (bus.forwardA_i == 2'b01) rs_res = bus.wb_data_i;
    if (bus.forwardA_i == 2'b10) rs_res = ex_result;
    if (bus.forwardB_i == 2'b01) rt_res = bus.wb_data_i;
    if (bus.forwardB_i == 2'b10) rt_res = ex_result;
    op_b = bus.idex_alu_src_i ? bus.idex_imm_i : rt_res;
  end

  // Single-cycle ALU; MUL goes through the iterative path and undefined ops give 0
  always_comb begin
    alu_res = '0;
    case (bus.idex_alu_op_i)
      OP_AND:  alu_res = rs_res & op_b;
      OP_OR:   alu_res = rs_res | op_b;
      OP_ADD:  alu_res = rs_res + op_b;
      OP_SUB:  alu_res = rs_res - op_b;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs_res) < $signed(op_b))};
      OP_MUL:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // EX/MEM pipeline register and MUL sequencing; every cycle defaults to a bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid  <= 1'b0;
      ex_result <= '0;
      ex_store  <= '0;
      ex_rd     <= '0;
      ex_ctrl   <= '0;
`ifdef EX_MUL_EN
      state     <= IDLE;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      mul_store <= '0;
      mul_rd    <= '0;
      mul_ctrl  <= '0;
`endif
    end else begin
      ex_valid  <= 1'b0;
      ex_result <= '0;
      ex_store  <= '0;
      ex_rd     <= '0;
      ex_ctrl   <= '0;
`ifdef EX_MUL_EN
      case (state)
        IDLE: begin
          if (mul_issue) begin
            state     <= BUSY;
            cnt       <= CNT_W'(MUL_CYC);
            mul_a     <= rs_res;
            mul_b     <= op_b;
            acc       <= '0;
            mul_store <= rt_res;
            mul_rd    <= bus.idex_rd_i;
            mul_ctrl  <= bus.idex_ctrl_i;
          end else if (bus.idex_valid_i) begin
            ex_valid  <= 1'b1;
            ex_result <= alu_res;
            ex_store  <= rt_res;
            ex_rd     <= bus.idex_rd_i;
            ex_ctrl   <= bus.idex_ctrl_i;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          mul_a <= mul_a << MUL_STEP;
          mul_b <= mul_b >> MUL_STEP;
          cnt   <= cnt - 1'b1;
          if (mul_done) begin
            state     <= IDLE;
            ex_valid  <= 1'b1;
            ex_result <= acc_next;
            ex_store  <= mul_store;
            ex_rd     <= mul_rd;
            ex_ctrl   <= mul_ctrl;
          end
        end
        default: state <= IDLE;
      endcase
`else
      if (bus.idex_valid_i) begin
        ex_valid  <= 1'b1;
        ex_result <= alu_res;
        ex_store  <= rt_res;
        ex_rd     <= bus.idex_rd_i;
        ex_ctrl   <= bus.idex_ctrl_i;
      end
`endif
    end
  end

  assign bus.stall_o        = stall;
  assign bus.exmem_valid_o  = ex_valid;
  assign bus.exmem_result_o = ex_result;
  assign bus.exmem_store_o  = ex_store;
  assign bus.exmem_rd_o     = ex_rd;
  assign bus.exmem_ctrl_o   = ex_ctrl;
endmodule
